riscv_dmem_reqbuf: RTL and testbench

//  Parametrised data-memory request buffer between the MEM stage and the dmem bus.

---
 rtl/riscv_dmem_reqbuf.sv | 126 ++++++++++++
 tb/tb_riscv_dmem_reqbuf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_reqbuf.sv
// riscv_dmem_reqbuf
//   In-order data-memory request buffer between the MEM stage and the dmem bus.
//   Holds up to DEPTH load/store requests, presents the oldest one on the bus
//   with a req/ack handshake and returns a one-cycle response per completed
//   access. A flush discards all entries that have not been issued; the head
//   entry is already on the bus and always completes.
//
// Ports
//   clk, rstn                   clock (rising edge), async active-low reset
//   flush                       discard unissued entries
//   req_valid/req_ready         MEM-stage push handshake (ready = not full)
//   req_adr/req_d/req_we/req_be request address, store data, store flag, byte enables
//   rsp_valid                   one-cycle completion pulse
//   rsp_q/rsp_we/rsp_err        load data, store flag, bus error of completed access
//   empty/level                 occupancy view for fences
//   dmem_req/adr/d/we/be        head entry presented to the bus
//   dmem_q/dmem_ack/dmem_err    bus read data, completion, error (qualified by ack)

module riscv_dmem_reqbuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [XLEN-1:0]              req_adr,
  input  logic [XLEN-1:0]              req_d,
  input  logic                         req_we,
  input  logic [XLEN/8-1:0]            req_be,
  output logic                         rsp_valid,
  output logic [XLEN-1:0]              rsp_q,
  output logic                         rsp_we,
  output logic                         rsp_err,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         dmem_req,
  output logic [XLEN-1:0]              dmem_adr,
  output logic [XLEN-1:0]              dmem_d,
  output logic                         dmem_we,
  output logic [XLEN/8-1:0]            dmem_be,
  input  logic [XLEN-1:0]              dmem_q,
  input  logic                         dmem_ack,
  input  logic                         dmem_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = XLEN/8;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [XLEN-1:0] adr_mem [DEPTH];
  logic [XLEN-1:0] d_mem   [DEPTH];
  logic            we_mem  [DEPTH];
  logic [BW-1:0]   be_mem  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] lvl;
  logic          push, pop;

  assign level      = lvl;
  assign empty      = (lvl == '0);
  assign req_ready  = (lvl != FULL_LVL);
  assign dmem_req   = !empty;
  assign push       = req_valid & req_ready & ~flush;
  assign pop        = dmem_req & dmem_ack;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // Bus fields come only from stored state; forced to zero while empty.
  always_comb begin
    dmem_adr = '0;
    dmem_d   = '0;
    dmem_we  = 1'b0;
    dmem_be  = '0;
    if (!empty) begin
      dmem_adr = adr_mem[rd_ptr];
      dmem_d   = d_mem[rd_ptr];
      dmem_we  = we_mem[rd_ptr];
      dmem_be  = be_mem[rd_ptr];
    end
  end

  // Payload storage needs no reset: it is only observed while level != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr] <= req_adr;
      d_mem[wr_ptr]   <= req_d;
      we_mem[wr_ptr]  <= req_we;
      be_mem[wr_ptr]  <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl       <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr_nxt;

      // Flush keeps only the issued head; if it completes this same edge the
      // buffer ends up empty with wr_ptr == new rd_ptr.
      if (flush && !empty) begin
        wr_ptr <= rd_ptr_nxt;
        lvl    <= pop ? '0 : CW'(1);
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (push && !pop)      lvl <= lvl + CW'(1);
        else if (!push && pop) lvl <= lvl - CW'(1);
      end

      rsp_valid <= pop;
      if (pop) begin
        rsp_we  <= we_mem[rd_ptr];
        rsp_err <= dmem_err;
        if (!we_mem[rd_ptr]) rsp_q <= dmem_q;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_reqbuf.sv
module tb_riscv_dmem_reqbuf;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  logic flush, req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_d;
  logic [3:0]  req_be;
  logic rsp_valid, rsp_we, rsp_err, empty;
  logic [31:0] rsp_q;
  logic [2:0]  level;
  logic dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [31:0] dmem_adr, dmem_d, dmem_q;
  logic [3:0]  dmem_be;

  riscv_dmem_reqbuf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
    .req_d(req_d), .req_we(req_we), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_we(rsp_we), .rsp_err(rsp_err),
    .empty(empty), .level(level),
    .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_d(dmem_d),
    .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_q(dmem_q), .dmem_ack(dmem_ack), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of pending requests plus response regs.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] d;
    logic        we;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  logic        m_rsp_valid, m_rsp_we, m_rsp_err;
  logic [31:0] m_rsp_q;
  bit          chk_on = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("req_ready", req_ready, mq.size() < DEPTH);
      chk("dmem_req", dmem_req, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("dmem_adr", dmem_adr, mq[0].adr);
        chk("dmem_d", dmem_d, mq[0].d);
        chk("dmem_we", dmem_we, mq[0].we);
        chk("dmem_be", dmem_be, mq[0].be);
      end else begin
        chk("dmem_fields_idle", {dmem_adr, dmem_d}, 64'd0);
        chk("dmem_we_be_idle", {dmem_we, dmem_be}, 64'd0);
      end
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      chk("rsp_we", rsp_we, m_rsp_we);
      chk("rsp_err", rsp_err, m_rsp_err);
      chk("rsp_q", rsp_q, m_rsp_q);
    end
  end

  task automatic model_reset();
    mq.delete();
    m_rsp_valid = 0; m_rsp_we = 0; m_rsp_err = 0; m_rsp_q = '0;
  endtask

  // Drives one cycle of inputs, advances the model, returns at negedge+1.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic we, input logic [3:0] be, input logic ack,
                      input logic [31:0] q, input logic err, input logic fl);
    bit   pop, push;
    ent_t h, n;
    req_valid = v; req_adr = a; req_d = d; req_we = we; req_be = be;
    dmem_ack = ack; dmem_q = q; dmem_err = err; flush = fl;
    pop  = (mq.size() != 0) && ack;
    push = v && (mq.size() < DEPTH) && !fl;
    m_rsp_valid = pop;
    if (pop) begin
      h = mq.pop_front();
      m_rsp_we  = h.we;
      m_rsp_err = err;
      if (!h.we) m_rsp_q = q;
    end
    if (fl) begin
      if (pop) mq.delete();
      else if (mq.size() != 0) begin
        h = mq[0];
        mq.delete();
        mq.push_back(h);
      end
    end else if (push) begin
      n.adr = a; n.d = d; n.we = we; n.be = be;
      mq.push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic we);
    step(1, a, d, we, 4'hF, 0, 0, 0, 0);
  endtask
  task automatic ack_only(input logic [31:0] q, input logic err);
    step(0, 0, 0, 0, 0, 1, q, err, 0);
  endtask

  initial begin
    rstn = 0; flush = 0; req_valid = 0; req_adr = 0; req_d = 0; req_we = 0;
    req_be = 0; dmem_q = 0; dmem_ack = 0; dmem_err = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    // 1: reset values
    chk("rst_empty", empty, 1);
    chk("rst_ready", req_ready, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_level", level, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rstn = 1;
    chk_on = 1;
    idle();

    // 2: single load, acked on the third cycle of dmem_req
    push_req(32'h100, 32'h0, 0);
    chk("t2_req_after_push", dmem_req, 1);
    chk("t2_adr", dmem_adr, 32'h100);
    idle();
    idle();
    chk("t2_req_held", dmem_req, 1);
    ack_only(32'hDEADBEEF, 0);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_q", rsp_q, 32'hDEADBEEF);
    chk("t2_rsp_we", rsp_we, 0);
    chk("t2_req_drop", dmem_req, 0);
    idle();
    chk("t2_rsp_pulse", rsp_valid, 0);

    // 3: fill, reject 5th, drain in order with continuous dmem_req
    for (int i = 0; i < 4; i++) push_req(32'h200 + 32'(4*i), 32'h1000 + 32'(i), 1);
    chk("t3_level_full", level, 4);
    chk("t3_ready_full", req_ready, 0);
    push_req(32'h2F0, 32'h5, 1);
    chk("t3_fifth_rejected", level, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order_adr", dmem_adr, 32'h200 + 32'(4*i));
      chk("t3_req_cont", dmem_req, 1);
      ack_only(0, 0);
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_we", rsp_we, 1);
    end
    chk("t3_level_zero", level, 0);

    // 4: push+ack on full, then push+ack at level 3
    for (int i = 0; i < 4; i++) push_req(32'h400 + 32'(4*i), 0, 1);
    step(1, 32'h4F0, 0, 1, 4'hF, 1, 0, 0, 0);
    chk("t4_full_pushpop", level, 3);
    step(1, 32'h4F4, 0, 1, 4'hF, 1, 0, 0, 0);
    chk("t4_l3_pushpop", level, 3);
    repeat (3) ack_only(0, 0);
    chk("t4_drained", level, 0);

    // 5: flush without ack keeps head; flush with ack empties
    for (int i = 0; i < 3; i++) push_req(32'h300 + 32'(4*i), 0, 0);
    step(1, 32'h3F0, 0, 0, 4'hF, 0, 0, 0, 1);
    chk("t5_flush_level", level, 1);
    chk("t5_flush_head", dmem_adr, 32'h300);
    push_req(32'h310, 0, 0);
    push_req(32'h314, 0, 0);
    chk("t5_refill", level, 3);
    step(0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 1);
    chk("t5_flushack_level", level, 0);
    chk("t5_flushack_rsp", rsp_valid, 1);
    chk("t5_flushack_q", rsp_q, 32'hCAFE0001);
    idle();

    // 6: store with bus error
    push_req(32'h500, 32'h77, 1);
    ack_only(32'h0, 1);
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_we", rsp_we, 1);
    chk("t6_rsp_err", rsp_err, 1);
    chk("t6_rsp_q_held", rsp_q, 32'hCAFE0001);

    // wrap: 3*DEPTH single push/ack pairs
    for (int i = 0; i < 3*DEPTH; i++) begin
      push_req(32'h600 + 32'(4*i), 32'(i), 0);
      chk("wrap_adr", dmem_adr, 32'h600 + 32'(4*i));
      ack_only(32'hA000 + 32'(i), 0);
      chk("wrap_q", rsp_q, 32'hA000 + 32'(i));
    end

    // ack while empty is ignored
    ack_only(32'h12345678, 0);
    chk("ack_idle_no_rsp", rsp_valid, 0);

    // randomized traffic, with one asynchronous reset mid-stream
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        rstn = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rstn = 1;
      end
      step($urandom_range(0, 99) < 60, $urandom, $urandom, 1'($urandom),
           4'($urandom), $urandom_range(0, 99) < 45, $urandom,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
